// File: rtl/vc_input_buffer.sv
`default_nettype none
// vc_input_buffer: two-VC input FIFOs with per-VC packet tracker and packet-locked output arbiter.
// rev 1.0

module vc_input_buffer #(
  parameter int         DEPTH   = 4,
  parameter logic [5:0] HEAD    = 6'b101111,
  parameter logic [7:0] TRAILER = 8'hFF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             i_in_flit,
  input  logic                   i_in_valid,
  input  logic                   i_in_vc,
  output logic [1:0]             o_in_ready,
  output logic [7:0]             o_out_flit,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic                   o_out_vc,
  output logic [$clog2(DEPTH):0] o_occ0,
  output logic [$clog2(DEPTH):0] o_occ1,
  output logic                   o_pkt_err
);

  localparam int OW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [OW-1:0] c_FULL = OW'(DEPTH);

  typedef enum logic {RX_IDLE = 1'b0, RX_PKT = 1'b1} rx_state_t;
  typedef enum logic [1:0] {ARB_IDLE = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} arb_state_t;

  logic [OW-1:0] w_occ [2];
  logic [7:0]    w_head [2];
  logic [1:0]    w_in_ready;
  logic [1:0]    w_nonempty;
  logic [1:0]    w_err;
  logic [1:0]    w_pop;
  logic          w_is_head;

  assign w_is_head = (i_in_flit[7:2] == HEAD);

  for (genvar v = 0; v < 2; v++) begin : g_vc
    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [OW-1:0] r_occ;
    rx_state_t     r_rx;
    rx_state_t     w_rx_nxt;
    logic          w_hs;
    logic          w_push;
    logic          w_drop_err;

    assign w_in_ready[v] = (r_occ < c_FULL);
    assign w_nonempty[v] = (r_occ != '0);
    assign w_occ[v]      = r_occ;
    assign w_head[v]     = r_mem[r_rd_ptr];
    assign w_err[v]      = w_drop_err;
    assign w_hs          = i_in_valid && (i_in_vc == 1'(v)) && w_in_ready[v];

    // Rejected flits still consume the handshake; a head inside a packet is kept as body.
    always_comb begin
      w_rx_nxt   = r_rx;
      w_push     = 1'b0;
      w_drop_err = 1'b0;
      if (w_hs) begin
        if (i_in_flit == 8'h00) begin
          w_drop_err = 1'b1;
        end else if (r_rx == RX_IDLE) begin
          if (w_is_head) begin
            w_push   = 1'b1;
            w_rx_nxt = RX_PKT;
          end else begin
            w_drop_err = 1'b1;
          end
        end else begin
          w_push = 1'b1;
          if (w_is_head) begin
            w_drop_err = 1'b1;
          end else if (i_in_flit == TRAILER) begin
            w_rx_nxt = RX_IDLE;
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_occ    <= '0;
        r_rx     <= RX_IDLE;
      end else begin
        r_rx <= w_rx_nxt;
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop[v]) r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push, w_pop[v]})
          2'b10:   r_occ <= r_occ + 1'b1;
          2'b01:   r_occ <= r_occ - 1'b1;
          default: r_occ <= r_occ;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_in_flit;
    end
  end

  arb_state_t r_arb;
  arb_state_t w_arb_nxt;
  logic       r_rr;
  logic       w_rr_nxt;
  logic       r_pkt_err;
  logic       w_sel;
  logic       w_out_valid;
  logic [7:0] w_out_flit;

  assign w_sel = (r_arb == LOCK1);

  // Once locked, the arbiter stays on its VC until the trailer leaves, even when starved.
  always_comb begin
    w_arb_nxt   = r_arb;
    w_rr_nxt    = r_rr;
    w_pop       = 2'b00;
    w_out_valid = 1'b0;
    w_out_flit  = 8'h00;
    case (r_arb)
      ARB_IDLE: begin
        if (&w_nonempty)        w_arb_nxt = r_rr ? LOCK1 : LOCK0;
        else if (w_nonempty[0]) w_arb_nxt = LOCK0;
        else if (w_nonempty[1]) w_arb_nxt = LOCK1;
      end
      LOCK0, LOCK1: begin
        w_out_valid = w_nonempty[w_sel];
        if (w_out_valid) begin
          w_out_flit = w_head[w_sel];
          if (i_out_ready) begin
            w_pop[w_sel] = 1'b1;
            if (w_head[w_sel] == TRAILER) begin
              w_arb_nxt = ARB_IDLE;
              w_rr_nxt  = ~w_sel;
            end
          end
        end
      end
      default: w_arb_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_arb     <= ARB_IDLE;
      r_rr      <= 1'b0;
      r_pkt_err <= 1'b0;
    end else begin
      r_arb     <= w_arb_nxt;
      r_rr      <= w_rr_nxt;
      r_pkt_err <= r_pkt_err | (|w_err);
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_flit  = w_out_flit;
  assign o_out_valid = w_out_valid;
  assign o_out_vc    = w_sel;
  assign o_occ0      = w_occ[0];
  assign o_occ1      = w_occ[1];
  assign o_pkt_err   = r_pkt_err;

endmodule

`default_nettype wire

// File: doc/vc_input_buffer.md
VC_INPUT_BUFFER -- requirements
Module: vc_input_buffer

Interface
REQ-001 Parameter: DEPTH, 4, entries per virtual-channel FIFO (power of two, >=2).
REQ-002 Parameter: HEAD, 6'b101111, head-flit marker in flit[7:2]; flit[1:0] is the destination node.
REQ-003 Parameter: TRAILER, 8'hFF, trailer-flit code.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 in_flit  input  8  flit from upstream link.
REQ-007 in_valid  input  1  in_flit valid this cycle.
REQ-008 in_vc  input  1  target VC (0/1) of in_flit.
REQ-009 in_ready  output  2  per-VC accept, bit v = VC v occupancy < DEPTH.
REQ-010 out_flit  output  8  flit to the switch controller flit_in_vc input.
REQ-011 out_valid  output  1  out_flit valid.
REQ-012 out_ready  input  1  switch controller consumes out_flit this cycle.
REQ-013 out_vc  output  1  VC currently granted.
REQ-014 occ0, occ1  output  clog2(DEPTH)+1 each  occupancy of VC0/VC1, 0..DEPTH.
REQ-015 pkt_err  output  1  sticky protocol-error flag.

Function
REQ-016 Push to VC v when in_valid && in_ready[v] && in_vc==v && flit accepted by REQ-018; flit stored at tail, occupancy +1 next cycle.
REQ-017 in_ready depends only on registered occupancy; no same-cycle pass-through of pop space to push.
REQ-018 Per-VC input tracker, states RX_IDLE/RX_PKT: in RX_IDLE only a head flit (flit[7:2]==HEAD) is stored, moves to RX_PKT; in RX_PKT all flits stored, TRAILER returns to RX_IDLE.
REQ-019 Flit presented with in_valid in RX_IDLE that is not a head, or any flit equal to 8'h00, SHALL be dropped (not stored, consumes in_ready handshake) and set pkt_err.
REQ-020 Head received in RX_PKT SHALL be stored as a body flit (no tracker change) and set pkt_err.
REQ-021 Output arbiter FSM, states ARB_IDLE, LOCK0, LOCK1, registered.
REQ-022 ARB_IDLE: candidates are VCs with occupancy>0; if both, grant the VC equal to round-robin pointer rr; if one, grant it; move to LOCKv next cycle; out_valid=0 in ARB_IDLE.
REQ-023 LOCKv: out_valid = (occ_v>0); out_flit = FIFO v head entry; out_vc=v.
REQ-024 Pop from VC v when LOCKv && out_valid && out_ready; occupancy -1 next cycle.
REQ-025 Popping a TRAILER returns FSM to ARB_IDLE and sets rr = ~v next cycle; other pops remain in LOCKv.
REQ-026 In LOCKv with FIFO v empty, FSM holds (packet not interleaved with other VC).
REQ-027 out_flit SHALL be 8'h00 whenever out_valid=0 (downstream treats nonzero as flit present).
REQ-028 out_flit/out_valid SHALL not change while out_valid=1 && out_ready=0.
REQ-029 Same-cycle push and pop on one VC: occupancy unchanged, both take effect, ordering preserved.
REQ-030 Pointers wrap modulo DEPTH; occupancy never exceeds DEPTH nor goes below 0.
REQ-031 Latency: head pushed on edge N to empty buffer in ARB_IDLE -> LOCK on edge N+1 -> out_valid=1 during cycle N+1 to N+2.
REQ-032 pkt_err cleared only by reset.

Reset
REQ-033 On rising clk with rst=0: both FIFOs empty, occ0=occ1=0, trackers RX_IDLE, FSM ARB_IDLE, rr=0, out_valid=0, out_flit=8'h00, out_vc=0, pkt_err=0, in_ready=2'b11 (from next cycle).
REQ-034 Reset mid-packet discards all buffered flits; FIFO storage contents need not be cleared.

Verification
REQ-035 Single packet VC0: push 8'hBE, 8'h12, 8'hFF -> out 8'hBE, 8'h12, 8'hFF in order, out_vc=0, FSM back to ARB_IDLE, pkt_err=0.
REQ-036 Both VCs hold a packet, rr=0 -> VC0 packet fully delivered, then VC1, rr=0 afterwards; no interleaving even with VC0 starved mid-packet.
REQ-037 Fill VC1 with head + 3 bodies (DEPTH=4) with out_ready=0 -> occ1=4, in_ready[1]=0, in_ready[0]=1; fifth push not stored.
REQ-038 Body flit 8'h33 to idle VC0 -> dropped, occ0=0, pkt_err=1 and stays 1.
REQ-039 Backpressure: out_ready=0 for 3 cycles on body flit -> out_flit stable, out_valid=1; same-cycle push+pop keeps occupancy constant.
REQ-040 rst=0 asserted mid-packet -> next cycle all outputs at REQ-033 values; new packet after release delivered normally.
